// File: rtl/iob_uart_dbg_bridge.sv
// iob_uart_dbg_bridge: lets a host on an 8N1 serial link issue single-beat
// IOb reads and writes. It receives framed commands, runs one bus
// transaction per command, and sends back read data, an ACK or a NAK.
module iob_uart_dbg_bridge #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int BAUD_DIV = 868,
  parameter int TIMEOUT  = 1000000
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                arst_i,
  input  logic                rs232_rxd_i,
  output logic                rs232_txd_o,
  output logic                rs232_rts_o,
  input  logic                rs232_cts_i,
  output logic                iob_valid_o,
  output logic [ADDR_W-1:0]   iob_addr_o,
  output logic [DATA_W-1:0]   iob_wdata_o,
  output logic [DATA_W/8-1:0] iob_wstrb_o,
  input  logic                iob_ready_i,
  input  logic                iob_rvalid_i,
  input  logic [DATA_W-1:0]   iob_rdata_i
);
  localparam int BW = $clog2(BAUD_DIV);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIV / 2 - 1);
  localparam logic [TW-1:0] TO_LIMIT  = TW'(TIMEOUT);
  localparam logic [7:0] OP_RD = 8'h52;
  localparam logic [7:0] OP_WR = 8'h57;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_BUS_REQ, S_BUS_RD, S_RESP, S_NAK
  } state_t;

  state_t          state, state_nxt;
  logic            rx_s1, rx_s2, rx_prev, rx_busy, rx_done, rx_ferr;
  logic [BW-1:0]   rx_cnt;
  logic [3:0]      rx_bit;
  logic [7:0]      rx_byte;
  logic            tx_busy, tx_end, tx_free, tx_ok, tx_load;
  logic [BW-1:0]   tx_cnt;
  logic [3:0]      tx_bit;
  logic [8:0]      tx_shift;
  logic [7:0]      tx_data;
  logic            is_wr, to_exp, resp_set;
  logic [1:0]      byte_cnt;
  logic [TW-1:0]   to_cnt;
  logic [31:0]     addr_sr, addr_nxt, data_nxt, resp_buf, resp_val;
  logic [23:0]     data_sr;
  logic [2:0]      resp_cnt, resp_n;

  assign addr_nxt = {rx_byte, addr_sr[31:8]};
  assign data_nxt = {rx_byte, data_sr};
  assign to_exp   = (to_cnt == TO_LIMIT);
  // The stop bit's last clock counts as free so reply bytes run back-to-back.
  assign tx_end   = tx_busy && (tx_bit == 4'd9) && (tx_cnt == '0);
  assign tx_free  = !tx_busy || tx_end;
  assign tx_ok    = tx_free && rs232_cts_i;

  // RX: synchronize, detect start edge, sample every bit at mid-bit.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_prev <= 1'b1;
      rx_busy <= 1'b0; rx_done <= 1'b0; rx_ferr <= 1'b0;
      rx_cnt <= '0; rx_bit <= 4'd0; rx_byte <= 8'h00;
    end else if (cke_i) begin
      rx_s1   <= rs232_rxd_i;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      rx_done <= 1'b0;
      rx_ferr <= 1'b0;
      if (!rx_busy) begin
        if (rx_prev && !rx_s2) begin
          rx_busy <= 1'b1;
          rx_cnt  <= BAUD_HALF;
          rx_bit  <= 4'd0;
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - BW'(1);
      end else begin
        rx_cnt <= BAUD_LAST;
        rx_bit <= rx_bit + 4'd1;
        if (rx_bit == 4'd0) begin
          if (rx_s2) rx_busy <= 1'b0;
        end else if (rx_bit == 4'd9) begin
          rx_busy <= 1'b0;
          rx_done <= rx_s2;
          rx_ferr <= !rx_s2;
        end else begin
          rx_byte <= {rx_s2, rx_byte[7:1]};
        end
      end
    end
  end

  // TX: shift out start, 8 data bits LSB first, stop; one bit per BAUD_DIV.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rs232_txd_o <= 1'b1; tx_busy <= 1'b0; tx_cnt <= '0;
      tx_bit <= 4'd0; tx_shift <= '1;
    end else if (cke_i) begin
      if (tx_load) begin
        rs232_txd_o <= 1'b0;
        tx_shift    <= {1'b1, tx_data};
        tx_bit      <= 4'd0;
        tx_cnt      <= BAUD_LAST;
        tx_busy     <= 1'b1;
      end else if (tx_busy) begin
        if (tx_cnt != '0) begin
          tx_cnt <= tx_cnt - BW'(1);
        end else if (tx_bit == 4'd9) begin
          tx_busy <= 1'b0;
        end else begin
          rs232_txd_o <= tx_shift[0];
          tx_shift    <= {1'b1, tx_shift[8:1]};
          tx_bit      <= tx_bit + 4'd1;
          tx_cnt      <= BAUD_LAST;
        end
      end
    end
  end

  // Parser next state; the first reply byte launches in the same cycle the
  // reply is decided so it starts one clock after the bus event.
  always_comb begin
    state_nxt = state;
    resp_set  = 1'b0;
    resp_val  = 32'h0;
    resp_n    = 3'd0;
    tx_load   = 1'b0;
    tx_data   = resp_buf[7:0];
    case (state)
      S_IDLE: if (rx_done) begin
        if (rx_byte == OP_RD || rx_byte == OP_WR) begin
          state_nxt = S_ADDR;
        end else begin
          state_nxt = S_NAK;
          resp_set = 1'b1; resp_val = {24'h0, NAK}; resp_n = 3'd1;
        end
      end
      S_ADDR: begin
        if (rx_ferr || to_exp) state_nxt = S_IDLE;
        else if (rx_done && byte_cnt == 2'd3) state_nxt = is_wr ? S_WDATA : S_BUS_REQ;
      end
      S_WDATA: begin
        if (rx_ferr || to_exp) state_nxt = S_IDLE;
        else if (rx_done && byte_cnt == 2'd3) state_nxt = S_BUS_REQ;
      end
      S_BUS_REQ: if (iob_ready_i) begin
        if (is_wr) begin
          state_nxt = S_RESP;
          resp_set = 1'b1; resp_val = {24'h0, ACK}; resp_n = 3'd1;
        end else if (iob_rvalid_i) begin
          state_nxt = S_RESP;
          resp_set = 1'b1; resp_val = iob_rdata_i; resp_n = 3'd4;
        end else begin
          state_nxt = S_BUS_RD;
        end
      end
      S_BUS_RD: if (iob_rvalid_i) begin
        state_nxt = S_RESP;
        resp_set = 1'b1; resp_val = iob_rdata_i; resp_n = 3'd4;
      end
      S_RESP, S_NAK: begin
        if (resp_cnt != 3'd0) tx_load = tx_ok;
        else if (tx_end) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (resp_set) begin
      tx_data = resp_val[7:0];
      tx_load = tx_ok;
    end
  end

  // Parser state, byte/timeout counters, reply queue and registered outputs.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state <= S_IDLE; is_wr <= 1'b0; byte_cnt <= 2'd0; to_cnt <= '0;
      resp_cnt <= 3'd0; resp_buf <= 32'h0; rs232_rts_o <= 1'b1;
      iob_valid_o <= 1'b0; iob_addr_o <= '0; iob_wdata_o <= '0; iob_wstrb_o <= '0;
    end else if (cke_i) begin
      state       <= state_nxt;
      rs232_rts_o <= (state_nxt == S_IDLE) || (state_nxt == S_ADDR) || (state_nxt == S_WDATA);
      iob_valid_o <= (state_nxt == S_BUS_REQ);
      if (state == S_IDLE && rx_done) is_wr <= (rx_byte == OP_WR);
      if ((state == S_ADDR || state == S_WDATA) && !to_exp) begin
        byte_cnt <= rx_done ? byte_cnt + 2'd1 : byte_cnt;
        to_cnt   <= rx_done ? '0 : to_cnt + TW'(1);
      end else begin
        byte_cnt <= 2'd0;
        to_cnt   <= '0;
      end
      if (state != S_BUS_REQ && state_nxt == S_BUS_REQ) begin
        iob_addr_o  <= is_wr ? addr_sr[ADDR_W-1:0] : addr_nxt[ADDR_W-1:0];
        iob_wdata_o <= is_wr ? data_nxt : '0;
        iob_wstrb_o <= is_wr ? '1 : '0;
      end
      if (resp_set) begin
        resp_buf <= tx_load ? {8'h00, resp_val[31:8]} : resp_val;
        resp_cnt <= tx_load ? resp_n - 3'd1 : resp_n;
      end else if (tx_load) begin
        resp_buf <= {8'h00, resp_buf[31:8]};
        resp_cnt <= resp_cnt - 3'd1;
      end
    end
  end

  // Little-endian assembly of the address and write-data fields.
  always_ff @(posedge clk_i) begin
    if (cke_i && rx_done) begin
      if (state == S_ADDR)  addr_sr <= addr_nxt;
      if (state == S_WDATA) data_sr <= {rx_byte, data_sr[23:8]};
    end
  end
endmodule

// File: tb/tb_iob_uart_dbg_bridge.sv
// Bench for iob_uart_dbg_bridge: serial host driver, serial reply decoder,
// IOb slave with memory, and a command-level model of expected results.
module tb_iob_uart_dbg_bridge;
  localparam int BAUD = 16;
  localparam int TMO  = 200;

  logic clk = 1'b0;
  logic cke, arst, rxd, txd, rts, cts, valid, ready, rvalid;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  wstrb;
  int cyc = 0;
  int checks = 0, failures = 0;

  iob_uart_dbg_bridge #(.DATA_W(32), .ADDR_W(32), .BAUD_DIV(BAUD), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .cke_i(cke), .arst_i(arst),
    .rs232_rxd_i(rxd), .rs232_txd_o(txd), .rs232_rts_o(rts), .rs232_cts_i(cts),
    .iob_valid_o(valid), .iob_addr_o(addr), .iob_wdata_o(wdata), .iob_wstrb_o(wstrb),
    .iob_ready_i(ready), .iob_rvalid_i(rvalid), .iob_rdata_i(rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Data returned for never-written addresses (shared slave/model behaviour).
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // Slave memory, updated only from observed bus writes.
  logic [31:0] smem [logic [31:0]];
  // Model memory, updated only from commands the host sent.
  logic [31:0] mmem [logic [31:0]];

  function automatic logic [31:0] srd(input logic [31:0] a);
    return smem.exists(a) ? smem[a] : dflt(a);
  endfunction
  function automatic logic [31:0] mrd(input logic [31:0] a);
    return mmem.exists(a) ? mmem[a] : dflt(a);
  endfunction

  // Serial reply decoder.
  logic [7:0] rx_q[$];
  int st_q[$];
  int stop_err = 0;
  initial begin
    logic [7:0] mb;
    int mt;
    forever begin
      @(posedge clk); #1;
      if (arst === 1'b0 && txd === 1'b0) begin
        mt = cyc;
        hold(BAUD / 2);
        for (int i = 0; i < 8; i++) begin
          hold(BAUD);
          mb[i] = txd;
        end
        hold(BAUD);
        if (txd !== 1'b1) stop_err++;
        rx_q.push_back(mb);
        st_q.push_back(mt);
      end
    end
  end

  // IOb slave with programmable ready / rvalid delays.
  int ready_dly = 0, rv_dly = 0, n_req = 0;
  logic [31:0] q_addr, q_wdata;
  logic [3:0]  q_wstrb;
  int q_vcyc, q_unstable, rdy_cyc, rv_cyc;
  logic q_after;
  initial begin
    ready = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (valid === 1'b1) begin
        n_req++;
        q_addr = addr; q_wdata = wdata; q_wstrb = wstrb;
        q_vcyc = 1; q_unstable = 0;
        for (int k = 0; k < ready_dly; k++) begin
          hold(1);
          if (valid === 1'b1) q_vcyc++;
          if (addr !== q_addr || wdata !== q_wdata || wstrb !== q_wstrb) q_unstable++;
        end
        ready = 1'b1; rdy_cyc = cyc;
        if (q_wstrb == 4'h0 && rv_dly == 0) begin
          rvalid = 1'b1; rdata = srd(q_addr); rv_cyc = cyc;
        end
        hold(1);
        ready = 1'b0; rvalid = 1'b0;
        q_after = valid;
        if (q_wstrb == 4'hF) smem[q_addr] = q_wdata;
        else if (rv_dly > 0) begin
          repeat (rv_dly - 1) begin @(posedge clk); #1; end
          rvalid = 1'b1; rdata = srd(q_addr); rv_cyc = cyc;
          hold(1);
          rvalid = 1'b0;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0; hold(BAUD);
    for (int i = 0; i < 8; i++) begin rxd = b[i]; hold(BAUD); end
    rxd = stop; hold(BAUD);
    rxd = 1'b1;
    if (!stop) hold(BAUD);
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
    send_byte(op, 1'b1);
    if (op == 8'h52 || op == 8'h57)
      for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], 1'b1);
    if (op == 8'h57)
      for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8], 1'b1);
  endtask

  task automatic clr();
    rx_q.delete(); st_q.delete();
  endtask

  task automatic run_cmd(input string tag, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] d, input int rdy, input int rv, input int nreq,
                         input logic [3:0] ws, input logic [31:0] reply, input int nrep);
    int req0, budget;
    logic [31:0] got;
    ready_dly = rdy; rv_dly = rv; req0 = n_req;
    send_cmd(op, a, d);
    budget = 0;
    while (rx_q.size() < nrep && budget < 6000) begin hold(1); budget++; end
    while (rts !== 1'b1 && budget < 6000) begin hold(1); budget++; end
    hold(2);
    check({tag, " done-in-budget"}, (budget < 6000) ? 1 : 0, 1);
    check({tag, " nreq"}, n_req - req0, nreq);
    check({tag, " nbytes"}, rx_q.size(), nrep);
    if (nreq == 1 && n_req - req0 == 1) begin
      check({tag, " addr"}, q_addr, a);
      check({tag, " wstrb"}, {28'h0, q_wstrb}, {28'h0, ws});
      if (op == 8'h57) check({tag, " wdata"}, q_wdata, d);
      check({tag, " valid-cycles"}, q_vcyc, rdy + 1);
      check({tag, " stable"}, q_unstable, 0);
      check({tag, " valid-drop"}, {31'h0, q_after}, 0);
      if (st_q.size() > 0)
        check({tag, " reply-latency"}, st_q[0] - ((op == 8'h57) ? rdy_cyc : rv_cyc), 1);
    end
    for (int i = 1; i < st_q.size(); i++)
      check({tag, " byte-spacing"}, st_q[i] - st_q[i-1], 10 * BAUD);
    got = 32'h0;
    for (int i = 0; i < rx_q.size() && i < 4; i++) got |= 32'(rx_q[i]) << (8 * i);
    check({tag, " reply"}, got, reply);
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [31:0] a, d;
    int          rdy, rv, nreq;
    logic [3:0]  ws;
    logic [31:0] reply;
    int          nrep;
  } vec_t;

  initial begin
    vec_t tbl[5];
    int req0, budget, bad_txd, bad_rts, rise;
    logic [7:0]  op;
    logic [31:0] a, d;

    tbl[0] = '{8'h57, 32'h10, 32'hDEADBEEF, 3, 0, 1, 4'hF, 32'h06,       1};
    tbl[1] = '{8'h52, 32'h04, 32'h0,        0, 0, 1, 4'h0, 32'h12345678, 4};
    tbl[2] = '{8'h52, 32'h04, 32'h0,        0, 5, 1, 4'h0, 32'h12345678, 4};
    tbl[3] = '{8'hAA, 32'h0,  32'h0,        0, 0, 0, 4'h0, 32'h15,       1};
    tbl[4] = '{8'h52, 32'h10, 32'h0,        1, 2, 1, 4'h0, 32'hDEADBEEF, 4};

    smem[32'h4] = 32'h12345678;
    mmem[32'h4] = 32'h12345678;
    cke = 1'b1; rxd = 1'b1; cts = 1'b1; arst = 1'b1;
    hold(5);
    check("reset txd", {31'h0, txd}, 1);
    check("reset rts", {31'h0, rts}, 1);
    check("reset valid", {31'h0, valid}, 0);
    check("reset addr", addr, 0);
    check("reset wdata", wdata, 0);
    check("reset wstrb", {28'h0, wstrb}, 0);
    arst = 1'b0;
    hold(5);

    for (int i = 0; i < 5; i++) begin
      clr();
      run_cmd($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].d, tbl[i].rdy, tbl[i].rv,
              tbl[i].nreq, tbl[i].ws, tbl[i].reply, tbl[i].nrep);
      if (tbl[i].op == 8'h57) mmem[tbl[i].a] = tbl[i].d;
    end

    // Randomized commands against the command-level memory model.
    for (int i = 0; i < 8; i++) begin
      op = ($urandom_range(0, 1) == 1) ? 8'h57 : 8'h52;
      a  = 32'h100 + 32'(4 * $urandom_range(0, 3));
      d  = $urandom;
      clr();
      if (op == 8'h57) begin
        run_cmd($sformatf("rnd%0d wr", i), op, a, d, $urandom_range(0, 4), 0, 1, 4'hF, 32'h06, 1);
        mmem[a] = d;
      end else begin
        run_cmd($sformatf("rnd%0d rd", i), op, a, d, $urandom_range(0, 4), $urandom_range(0, 4),
                1, 4'h0, mrd(a), 4);
      end
    end

    // Partial command abandoned by the inter-byte timeout.
    clr();
    send_byte(8'h57, 1'b1);
    send_byte(8'h10, 1'b1);
    hold(300);
    run_cmd("timeout", 8'h52, 32'h0, 32'h0, 0, 0, 1, 4'h0, mrd(32'h0), 4);

    // Opcode byte with a bad stop bit is discarded silently.
    clr();
    send_byte(8'h57, 1'b0);
    run_cmd("framing", 8'h52, 32'h4, 32'h0, 0, 0, 1, 4'h0, 32'h12345678, 4);
    check("no stop errors on replies", stop_err, 0);

    // Write ACK held back while the peer deasserts CTS.
    clr(); cts = 1'b0; ready_dly = 0; rv_dly = 0; req0 = n_req;
    send_cmd(8'h57, 32'h20, 32'hCAFEF00D);
    bad_txd = 0; bad_rts = 0;
    repeat (100) begin
      hold(1);
      if (txd !== 1'b1) bad_txd++;
      if (rts !== 1'b0) bad_rts++;
    end
    check("flow nreq", n_req - req0, 1);
    check("flow txd idle", bad_txd, 0);
    check("flow rts low", bad_rts, 0);
    cts = 1'b1; budget = 0; rise = -1;
    while (budget < 4000 && rise < 0) begin
      hold(1); budget++;
      if (rts === 1'b1) rise = cyc;
    end
    mmem[32'h20] = 32'hCAFEF00D;
    check("flow rts rise seen", (rise >= 0) ? 1 : 0, 1);
    check("flow nbytes", rx_q.size(), 1);
    if (rx_q.size() > 0) check("flow ack", {24'h0, rx_q[0]}, 32'h06);
    if (st_q.size() > 0) check("flow rts until stop end", rise - st_q[0], 10 * BAUD);

    // Reset while a read reply waits on CTS: everything returns to reset values.
    clr(); cts = 1'b0; ready_dly = 0; rv_dly = 0;
    send_cmd(8'h52, 32'h4, 32'h0);
    hold(4);
    check("pre-reset rts", {31'h0, rts}, 0);
    arst = 1'b1;
    hold(2);
    check("mid-reset rts", {31'h0, rts}, 1);
    check("mid-reset valid", {31'h0, valid}, 0);
    check("mid-reset addr", addr, 0);
    check("mid-reset txd", {31'h0, txd}, 1);
    arst = 1'b0; cts = 1'b1;
    hold(20 * BAUD);
    check("no reply after reset", rx_q.size(), 0);
    clr();
    run_cmd("after-reset", 8'h52, 32'h20, 32'h0, 0, 0, 1, 4'h0, mrd(32'h20), 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
